bsg_counter_window_sched: RTL and testbench

Round-robin scheduler that shares one saturating clear/up event counter among num_req_p requesters over fixed-length measurement windows.
- Each window: grants at most one request per cycle, with one counter increment per grant.
- At window end: presents the count as a snapshot over valid/ready, then clears the counter.
- Sits between event sources (cache/NoC perf events) and the perf-counter readout path.

---
 rtl/bsg_counter_window_sched.sv | 156 +++++++++++++++
 tb/tb_bsg_counter_window_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_window_sched.sv
// Round-robin window scheduler around a shared saturating event counter; the count is
// snapshotted over valid/ready at each window end. Optional: BSG_COUNTER_WINDOW_SCHED_OVF_EN.
module bsg_counter_window_sched #(
  parameter int num_req_p = 4,
  parameter int max_val_p = 64,
  parameter int window_p  = 256,
  localparam int cw = $clog2(max_val_p + 1),
  localparam int tw = $clog2(window_p),
  localparam int pw = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [num_req_p-1:0] req_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [cw-1:0]        count_o,
  output logic                 snap_v_o,
  output logic [cw-1:0]        snap_count_o,
  input  logic                 snap_ready_i
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
  , output logic               snap_ovf_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REPORT} state_e;

  localparam logic [cw-1:0] c_max   = cw'(max_val_p);
  localparam logic [tw-1:0] c_tlast = tw'(window_p - 1);
  localparam logic [pw-1:0] c_plast = pw'(num_req_p - 1);

  state_e                 r_state, w_state_n;
  logic [cw-1:0]          r_count, w_count_n;
  logic [tw-1:0]          r_timer, w_timer_n;
  logic [pw-1:0]          r_ptr, w_ptr_n;
  logic                   r_snap_v, w_snap_v_n;
  logic [cw-1:0]          r_snap_count, w_snap_count_n;
  logic [num_req_p-1:0]   w_grant;
  logic [pw-1:0]          w_hit_idx;
  logic [pw-1:0]          w_cand;
  logic                   w_hit;
  logic                   w_grant_v;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
  logic                   r_ovf, w_ovf_n;
`endif

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = r_ptr;
    w_cand    = r_ptr;
    for (int i = 0; i < num_req_p; i++) begin
      w_cand = pw'((int'(r_ptr) + i) % num_req_p);
      if (!w_hit && req_i[w_cand]) begin
        w_hit     = 1'b1;
        w_hit_idx = w_cand;
      end
    end
    w_grant = '0;
    if (r_state == S_COUNT && !clear_i && w_hit) w_grant[w_hit_idx] = 1'b1;
    w_grant_v = |w_grant;
  end

  always_comb begin
    w_state_n      = r_state;
    w_count_n      = r_count;
    w_timer_n      = r_timer;
    w_ptr_n        = r_ptr;
    w_snap_v_n     = r_snap_v;
    w_snap_count_n = r_snap_count;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
    w_ovf_n        = r_ovf;
`endif
    if (clear_i) begin
      w_state_n  = S_IDLE;
      w_count_n  = '0;
      w_timer_n  = '0;
      w_snap_v_n = 1'b0;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
      w_ovf_n    = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            w_state_n = S_COUNT;
            w_timer_n = '0;
          end
        end
        S_COUNT: begin
          if (w_grant_v) begin
            w_ptr_n = (w_hit_idx == c_plast) ? '0 : w_hit_idx + pw'(1);
            if (r_count < c_max) w_count_n = r_count + cw'(1);
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
            else w_ovf_n = 1'b1;
`endif
          end
          // The last-cycle grant is already folded into w_count_n here.
          if (r_timer == c_tlast) begin
            w_state_n      = S_REPORT;
            w_timer_n      = '0;
            w_snap_v_n     = 1'b1;
            w_snap_count_n = w_count_n;
          end else begin
            w_timer_n = r_timer + tw'(1);
          end
        end
        S_REPORT: begin
          if (snap_ready_i) begin
            w_count_n  = '0;
            w_snap_v_n = 1'b0;
            w_timer_n  = '0;
            w_state_n  = en_i ? S_COUNT : S_IDLE;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
            w_ovf_n    = 1'b0;
`endif
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_timer      <= '0;
      r_ptr        <= '0;
      r_snap_v     <= 1'b0;
      r_snap_count <= '0;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
      r_ovf        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_count      <= w_count_n;
      r_timer      <= w_timer_n;
      r_ptr        <= w_ptr_n;
      r_snap_v     <= w_snap_v_n;
      r_snap_count <= w_snap_count_n;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
      r_ovf        <= w_ovf_n;
`endif
    end
  end

  assign grant_o      = w_grant;
  assign count_o      = r_count;
  assign snap_v_o     = r_snap_v;
  assign snap_count_o = r_snap_count;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
  assign snap_ovf_o   = r_snap_v & r_ovf;
`endif

endmodule

// File: tb/tb_bsg_counter_window_sched.sv
// Directed bench for bsg_counter_window_sched: a short-window instance (a) and a
// default-window instance (b), checked every cycle against a window-level model.
module tb_bsg_counter_window_sched;

  localparam int NREQ = 4;
  localparam int MAXV = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear, en_a, en_b, rdy_a, rdy_b;
  logic [3:0] req;
  logic [3:0] grant_a, grant_b;
  logic [6:0] count_a, count_b, snap_count_a, snap_count_b;
  logic       snap_v_a, snap_v_b;
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
  logic       ovf_a, ovf_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_counter_window_sched #(.num_req_p(NREQ), .max_val_p(MAXV), .window_p(8)) u_dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a), .clear_i(clear), .req_i(req),
    .grant_o(grant_a), .count_o(count_a), .snap_v_o(snap_v_a),
    .snap_count_o(snap_count_a), .snap_ready_i(rdy_a)
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
    , .snap_ovf_o(ovf_a)
`endif
  );

  bsg_counter_window_sched #(.num_req_p(NREQ), .max_val_p(MAXV), .window_p(256)) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b), .clear_i(clear), .req_i(req),
    .grant_o(grant_b), .count_o(count_b), .snap_v_o(snap_v_b),
    .snap_count_o(snap_count_b), .snap_ready_i(rdy_b)
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
    , .snap_ovf_o(ovf_b)
`endif
  );

  // Model: mode 0 idle, 1 counting, 2 reporting; t = cycles spent in the window.
  int m_mode[2], m_t[2], m_cnt[2], m_ptr[2], m_sv[2], m_sc[2], m_ovf[2];

  function automatic int win(input int k);
    return (k == 0) ? 8 : 256;
  endfunction

  function automatic int gidx(input int k);
    if (m_mode[k] != 1 || clear) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req[(m_ptr[k] + i) % NREQ]) return (m_ptr[k] + i) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g, e, r;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_t[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        m_sv[k] = 0; m_sc[k] = 0; m_ovf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        g = gidx(k);
        e = (k == 0) ? int'(en_a) : int'(en_b);
        r = (k == 0) ? int'(rdy_a) : int'(rdy_b);
        if (clear) begin
          m_mode[k] = 0; m_t[k] = 0; m_cnt[k] = 0; m_sv[k] = 0; m_ovf[k] = 0;
        end else if (m_mode[k] == 0) begin
          if (e != 0) begin m_mode[k] = 1; m_t[k] = 0; end
        end else if (m_mode[k] == 1) begin
          if (g >= 0) begin
            m_ptr[k] = (g + 1) % NREQ;
            if (m_cnt[k] < MAXV) m_cnt[k] = m_cnt[k] + 1;
            else m_ovf[k] = 1;
          end
          if (m_t[k] == win(k) - 1) begin
            m_mode[k] = 2; m_t[k] = 0; m_sv[k] = 1; m_sc[k] = m_cnt[k];
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end else if (r != 0) begin
          m_cnt[k] = 0; m_sv[k] = 0; m_ovf[k] = 0; m_t[k] = 0;
          m_mode[k] = (e != 0) ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gexp(input int k);
    int g;
    g = gidx(k);
    return (g < 0) ? 0 : (1 << g);
  endfunction

  always @(negedge clk) begin
    chk("a.grant", grant_a, gexp(0));
    chk("a.count", count_a, m_cnt[0]);
    chk("a.snap_v", snap_v_a, m_sv[0]);
    chk("a.snap_count", snap_count_a, m_sc[0]);
    chk("b.grant", grant_b, gexp(1));
    chk("b.count", count_b, m_cnt[1]);
    chk("b.snap_v", snap_v_b, m_sv[1]);
    chk("b.snap_count", snap_count_b, m_sc[1]);
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
    chk("a.ovf", ovf_a, m_sv[0] & m_ovf[0]);
    chk("b.ovf", ovf_b, m_sv[1] & m_ovf[1]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; req = 4'h0; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.snap_v", snap_v_a, 0);
    chk("rst.count", count_a, 0);
    chk("rst.grant", grant_a, 0);
    chk("rst.snap_count", snap_count_a, 0);
    step();
    rst_n = 1'b1;

    // Empty window: snapshot of 0 arrives on the 9th edge after enabling
    en_a = 1'b1;
    repeat (8) begin
      step();
      @(negedge clk);
      chk("t1.grant", grant_a, 0);
      chk("t1.snap_v_early", snap_v_a, 0);
    end
    step();
    @(negedge clk);
    chk("t1.snap_v", snap_v_a, 1);
    chk("t1.snap_count", snap_count_a, 0);
    rdy_a = 1'b1; en_a = 1'b0;
    step();
    rdy_a = 1'b0;
    @(negedge clk);
    chk("t1.snap_v_after", snap_v_a, 0);

    // Full requests rotate; en dropped mid-window
    req = 4'hF; en_a = 1'b1;
    step();
    en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2.grant", grant_a, 1 << (i % 4));
      step();
    end
    @(negedge clk);
    chk("t2.snap_v", snap_v_a, 1);
    chk("t2.snap_count", snap_count_a, 8);

    // Back-pressure in REPORT
    for (int i = 0; i < 10; i++) begin
      req = i[0] ? 4'hA : 4'h5;
      @(negedge clk);
      chk("t4.snap_v", snap_v_a, 1);
      chk("t4.snap_count", snap_count_a, 8);
      chk("t4.count", count_a, 8);
      chk("t4.grant", grant_a, 0);
      step();
    end
    rdy_a = 1'b1;
    @(negedge clk);
    chk("t4.snap_v_c11", snap_v_a, 1);
    step();
    rdy_a = 1'b0;
    @(negedge clk);
    chk("t2.count_after_hs", count_a, 0);
    chk("t4.snap_v_after", snap_v_a, 0);

    // Clear at timer 5 with req 0101
    req = 4'h5; en_a = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5.grant", grant_a, (i % 2 == 0) ? 1 : 4);
      step();
    end
    clear = 1'b1;
    @(negedge clk);
    chk("t5.grant_clear", grant_a, 0);
    chk("t5.count_pre", count_a, 5);
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t5.count_cleared", count_a, 0);
    chk("t5.snap_v", snap_v_a, 0);
    chk("t5.idle_grant", grant_a, 0);
    step();
    @(negedge clk);
    chk("t5.grant_resume", grant_a, 4);
    clear = 1'b1; en_a = 1'b0;
    step();
    clear = 1'b0;

    // Saturation over a 256-cycle window
    req = 4'hF; en_b = 1'b1;
    step();
    en_b = 1'b0;
    repeat (256) step();
    @(negedge clk);
    chk("t3.snap_v", snap_v_b, 1);
    chk("t3.snap_count", snap_count_b, 64);
    chk("t3.count", count_b, 64);
`ifdef BSG_COUNTER_WINDOW_SCHED_OVF_EN
    chk("t3.ovf", ovf_b, 1);
`endif
    rdy_b = 1'b1;
    step();
    rdy_b = 1'b0;
    @(negedge clk);
    chk("t3.count_after", count_b, 0);
    chk("t3.snap_v_after", snap_v_b, 0);

    // Asynchronous reset in REPORT
    req = 4'hF; en_a = 1'b1;
    step();
    en_a = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("t6.snap_v_pre", snap_v_a, 1);
    chk("t6.count_pre", count_a, 8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.snap_v", snap_v_a, 0);
    chk("t6.count", count_a, 0);
    chk("t6.grant", grant_a, 0);
    chk("t6.snap_count", snap_count_a, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
